// File: rtl/dmem_access_ctrl.sv
// Byte-serial, big-endian data-memory sequencer for the MEM stage.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned word/half ops instead of accessing memory).
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              addr_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_LH   = 3'b010;
    localparam logic [2:0] OP_LHU  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_SH   = 3'b101;
    localparam logic [2:0] OP_SB   = 3'b110;
    localparam logic [2:0] OP_LB   = 3'b111;

    logic [1:0]        r_state;
    logic [1:0]        r_state_nxt;
    logic [2:0]        r_op;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_sdata;
    logic [23:0]       r_asm;
    logic [31:0]       r_rdata;
    logic              r_mem_we;
    logic              r_done;
    logic              r_addr_err;

    logic              w_accept;
    logic              w_last;
    logic              w_misalign;
    logic [31:0]       w_store_aligned;
    logic [31:0]       w_word;
    logic [31:0]       w_load_val;
    logic              w_unused;

    // Index of the final byte: 3 for word, 1 for half, 0 for byte ops.
    function automatic logic [1:0] f_last_cnt(input logic [2:0] o);
        case (o)
            OP_LW, OP_SW:         f_last_cnt = 2'd3;
            OP_LH, OP_LHU, OP_SH: f_last_cnt = 2'd1;
            default:              f_last_cnt = 2'd0;
        endcase
    endfunction

    function automatic logic f_is_store(input logic [2:0] o);
        f_is_store = (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
    endfunction

    assign w_unused = ^addr[31:ADDR_W];

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((f_last_cnt(op) == 2'd3) && (addr[1:0] != 2'b00)) ||
                        ((f_last_cnt(op) == 2'd1) && addr[0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && req && (op != OP_NONE);
    assign w_last   = (r_cnt == f_last_cnt(r_op));

    // Store data left-aligned so the next byte out is always the top byte.
    always_comb begin
        w_store_aligned = {wdata[7:0], 24'h000000};
        case (op)
            OP_SW:   w_store_aligned = wdata;
            OP_SH:   w_store_aligned = {wdata[15:0], 16'h0000};
            default: w_store_aligned = {wdata[7:0], 24'h000000};
        endcase
    end

    assign w_word = {r_asm, mem_rdata};

    always_comb begin
        w_load_val = w_word;
        case (r_op)
            OP_LH:   w_load_val = {{16{w_word[15]}}, w_word[15:0]};
            OP_LHU:  w_load_val = {16'h0000, w_word[15:0]};
            OP_LB:   w_load_val = {{24{w_word[7]}}, w_word[7:0]};
            default: w_load_val = w_word;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) r_state_nxt = w_misalign ? S_DONE : S_ACCESS;
            end
            S_ACCESS: begin
                if (w_last) r_state_nxt = S_DONE;
            end
            S_DONE:  r_state_nxt = S_IDLE;
            default: r_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= r_state_nxt;
    end

    // Datapath: every memory-facing output changes only on a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= OP_NONE;
            r_cnt      <= 2'd0;
            r_mem_addr <= '0;
            r_sdata    <= 32'h0;
            r_asm      <= 24'h0;
            r_rdata    <= 32'h0;
            r_mem_we   <= 1'b0;
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_cnt <= 2'd0;
                        r_asm <= 24'h0;
                        if (w_misalign) begin
                            r_done     <= 1'b1;
                            r_addr_err <= 1'b1;
                        end else begin
                            r_mem_addr <= addr[ADDR_W-1:0];
                            r_sdata    <= w_store_aligned;
                            r_mem_we   <= f_is_store(op);
                        end
                    end
                end
                S_ACCESS: begin
                    r_asm <= {r_asm[15:0], mem_rdata};
                    if (w_last) begin
                        r_mem_we <= 1'b0;
                        r_done   <= 1'b1;
                        if (!f_is_store(r_op)) r_rdata <= w_load_val;
                    end else begin
                        r_cnt      <= r_cnt + 2'd1;
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        r_sdata    <= {r_sdata[23:0], 8'h00};
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall     = (r_state == S_ACCESS) || w_accept;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_sdata[31:24];
    assign mem_we    = r_mem_we;
    assign addr_err  = r_addr_err;

endmodule
